// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Far end of the fetch stage's instruction request interface. Accepts one
//   word-aligned fetch address per request handshake. After WAIT_CYCLES wait
//   states it presents the 32-bit instruction (or an access fault) on a
//   valid/ready response channel. A side loader port writes program words
//   into the store at any time.
//
// Ports
//   i_clk, i_rstn        clock (rising edge), asynchronous active-low reset
//   i_req_valid/o_req_ready/i_req_addr   fetch request channel (byte address)
//   o_rsp_valid/i_rsp_ready              response handshake
//   o_rsp_data, o_rsp_err                instruction word, access fault flag
//   i_ld_we/i_ld_addr/i_ld_data          loader write port (same mapping)
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  input  logic        i_ld_we,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Access fault: misaligned, below the base, or beyond the last word.
  // off is the byte offset a - BASE_ADDR; since BASE_ADDR is word aligned,
  // off[1:0] equals a[1:0].
  function automatic logic addr_fault(input logic [31:0] a, input logic [31:0] off);
    addr_fault = (off[1:0] != 2'b00) || (a < BASE_ADDR) ||
                 ({2'b00, off[31:2]} >= DEPTH_LIM);
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q;
  logic               err_q;
  logic               latch_s;
  logic [31:0]        rd_addr_s;
  logic [31:0]        rd_off_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic               rd_err_s;
  logic [31:0]        ld_off_s;
  logic [IDX_W-1:0]   ld_idx_s;
  logic               ld_ok_s;

  logic [31:0]        mem_q [DEPTH_WORDS];

  assign rd_off_s = rd_addr_s - BASE_ADDR;
  assign rd_idx_s = rd_off_s[IDX_W+1:2];
  assign rd_err_s = addr_fault(rd_addr_s, rd_off_s);

  assign ld_off_s = i_ld_addr - BASE_ADDR;
  assign ld_idx_s = ld_off_s[IDX_W+1:2];
  assign ld_ok_s  = i_ld_we && !addr_fault(i_ld_addr, ld_off_s);

  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_data  = data_q;
  assign o_rsp_err   = err_q;

  // Next-state logic. The read address is the live request address when RESP
  // is entered straight from a handshake (zero wait states), else the
  // captured one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    latch_s     = 1'b0;
    rd_addr_s   = i_req_addr;
    o_req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          addr_d = i_req_addr;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            latch_s = 1'b1;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        rd_addr_s = addr_q;
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          latch_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // Accepting a new request while the current response retires keeps
        // the pipe full.
        o_req_ready = i_rsp_ready;
        if (i_rsp_ready) begin
          if (i_req_valid) begin
            addr_d = i_req_addr;
            if (WAIT_CYCLES == 0) begin
              state_d = S_RESP;
              latch_s = 1'b1;
            end else begin
              cnt_d   = WAIT_LOAD;
              state_d = S_WAIT;
            end
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and response registers. The store is read only on the
  // latch edge; a loader write on that same edge lands after the read.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (latch_s) begin
        err_q  <= rd_err_s;
        data_q <= rd_err_s ? 32'h0000_0000 : mem_q[rd_idx_s];
      end
    end
  end

  // Instruction store write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (ld_ok_s) begin
      mem_q[ld_idx_s] <= i_ld_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] due;
  } exp_t;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        ld_we     [2];
  logic [31:0] ld_addr   [2];
  logic [31:0] ld_data   [2];

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rdy_mode [2];
  logic [31:0] mdl [2][1024];
  exp_t        sbq [2][$];
  logic        fresh [2];
  logic        stall_prev [2];
  logic [31:0] held_data [2];
  logic        held_err [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // unit 0: 1024 words, 2 wait states; unit 1: 16 words, no wait states
  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_responder #(
      .DEPTH_WORDS(g == 0 ? 1024 : 16),
      .WAIT_CYCLES(g == 0 ? 2 : 0),
      .BASE_ADDR  (BASE)
    ) u_dut (
      .i_clk      (clk),
      .i_rstn     (rstn),
      .i_req_valid(req_valid[g]),
      .o_req_ready(req_ready[g]),
      .i_req_addr (req_addr[g]),
      .o_rsp_valid(rsp_valid[g]),
      .i_rsp_ready(rsp_ready[g]),
      .o_rsp_data (rsp_data[g]),
      .o_rsp_err  (rsp_err[g]),
      .i_ld_we    (ld_we[g]),
      .i_ld_addr  (ld_addr[g]),
      .i_ld_data  (ld_data[g])
    );
  end

  function automatic int depth_of(int u);
    return (u == 0) ? 1024 : 16;
  endfunction

  function automatic int wait_of(int u);
    return (u == 0) ? 2 : 0;
  endfunction

  // Word index of a byte address, or -1 when the access faults.
  function automatic int word_of(int u, logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    if ((a % 4) != 0 || off < 0 || (off / 4) >= depth_of(u)) return -1;
    return int'(off / 4);
  endfunction

  function automatic exp_t predict(int u, logic [31:0] a, int c);
    exp_t e;
    int   w;
    w      = word_of(u, a);
    e.err  = (w < 0);
    e.data = (w < 0) ? 32'h0 : mdl[u][w];
    e.due  = 32'(c + 1 + wait_of(u));
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Caller sits just after a rising edge; returns just after the handshake edge.
  task automatic issue(int u, logic [31:0] a);
    int guard;
    guard = 0;
    req_valid[u] = 1'b1;
    req_addr[u]  = a;
    forever begin
      @(negedge clk);
      if (req_ready[u]) begin
        sbq[u].push_back(predict(u, a, cyc));
        @(posedge clk); #2;
        break;
      end
      @(posedge clk); #2;
      guard++;
      if (guard > 100) begin
        flag_fail("req_timeout");
        break;
      end
    end
  endtask

  task automatic idle(int u);
    req_valid[u] = 1'b0;
  endtask

  task automatic ld(int u, logic [31:0] a, logic [31:0] d);
    int w;
    ld_we[u]   = 1'b1;
    ld_addr[u] = a;
    ld_data[u] = d;
    @(posedge clk); #2;
    ld_we[u] = 1'b0;
    w = word_of(u, a);
    if (w >= 0) mdl[u][w] = d;
  endtask

  task automatic drain(int u);
    int guard;
    guard = 0;
    while (sbq[u].size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sbq[u].size() != 0) begin
      flag_fail("drain_timeout");
      sbq[u].delete();
    end
    @(posedge clk); #2;
  endtask

  // Response-ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        case (rdy_mode[u])
          1:       rsp_ready[u] = ($urandom_range(0, 3) != 0);
          2:       rsp_ready[u] = 1'b0;
          default: rsp_ready[u] = 1'b1;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (!rstn) begin
          fresh[u]      = 1'b1;
          stall_prev[u] = 1'b0;
        end else begin
          if (stall_prev[u]) begin
            chk("hold_valid", 32'(rsp_valid[u]), 32'd1);
            chk("hold_data", rsp_data[u], held_data[u]);
            chk("hold_err", 32'(rsp_err[u]), 32'(held_err[u]));
          end
          if (rsp_valid[u]) begin
            if (sbq[u].size() == 0) begin
              flag_fail("spurious_rsp");
              stall_prev[u] = 1'b0;
            end else begin
              if (fresh[u]) begin
                chk("latency", 32'(cyc), sbq[u][0].due);
                fresh[u] = 1'b0;
              end
              if (rsp_ready[u]) begin
                e = sbq[u].pop_front();
                chk("rsp_data", rsp_data[u], e.data);
                chk("rsp_err", 32'(rsp_err[u]), 32'(e.err));
                fresh[u]      = 1'b1;
                stall_prev[u] = 1'b0;
              end else begin
                chk("req_ready_stall", 32'(req_ready[u]), 32'd0);
                stall_prev[u] = 1'b1;
                held_data[u]  = rsp_data[u];
                held_err[u]   = rsp_err[u];
              end
            end
          end else begin
            stall_prev[u] = 1'b0;
            if (sbq[u].size() != 0 && 32'(cyc) >= sbq[u][0].due) begin
              flag_fail("late_rsp");
              void'(sbq[u].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, r;
    logic [31:0] a;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_addr[u] = 32'h0;
      ld_we[u] = 1'b0; ld_addr[u] = 32'h0; ld_data[u] = 32'h0;
      rdy_mode[u] = 0; fresh[u] = 1'b1; stall_prev[u] = 1'b0;
    end
    rstn = 1'b0;
    #12;
    for (int u = 0; u < 2; u++) begin
      chk("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
      chk("rst_rsp_data", rsp_data[u], 32'h0);
      chk("rst_rsp_err", 32'(rsp_err[u]), 32'd0);
      chk("rst_req_ready", 32'(req_ready[u]), 32'd1);
    end
    @(posedge clk); #2;
    rstn = 1'b1;

    // preload both stores so every in-range word has a known value
    for (int i = 0; i < 1024; i++) begin
      ld_we[0] = 1'b1; ld_addr[0] = 32'(i * 4); ld_data[0] = $urandom;
      ld_we[1] = (i < 16); ld_addr[1] = 32'(i * 4); ld_data[1] = $urandom;
      @(posedge clk); #2;
      mdl[0][i] = ld_data[0];
      if (i < 16) mdl[1][i] = ld_data[1];
      ld_we[0] = 1'b0; ld_we[1] = 1'b0;
    end

    // first fetch, 2 wait states
    ld(0, 32'h0, 32'h0050_0093);
    issue(0, 32'h0); idle(0); drain(0);

    // response stall
    rdy_mode[0] = 2;
    issue(0, 32'h8); idle(0);
    repeat (8) @(posedge clk);
    #2;
    rdy_mode[0] = 0;
    drain(0);
    chk("idle_req_ready", 32'(req_ready[0]), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid[0]), 32'd0);

    // faults then a good fetch
    issue(0, 32'h2); issue(0, 32'h1000); issue(0, 32'h0); idle(0); drain(0);

    // loader write on the read-latch edge returns old data
    ld(0, 32'h10, 32'h5555_5555);
    issue(0, 32'h10); idle(0);
    @(posedge clk); #2;
    ld_we[0] = 1'b1; ld_addr[0] = 32'h10; ld_data[0] = 32'hAAAA_AAAA;
    @(posedge clk); #2;
    ld_we[0] = 1'b0;
    mdl[0][4] = 32'hAAAA_AAAA;
    drain(0);
    issue(0, 32'h10); idle(0); drain(0);

    // loader write during the wait states is visible to the read
    mdl[0][5] = 32'h1234_5678;
    issue(0, 32'h14); idle(0);
    ld_we[0] = 1'b1; ld_addr[0] = 32'h14; ld_data[0] = 32'h1234_5678;
    @(posedge clk); #2;
    ld_we[0] = 1'b0;
    drain(0);

    // reset during the wait states
    issue(0, 32'h20); idle(0);
    rstn = 1'b0;
    #1;
    chk("rst_wait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_wait_req_ready", 32'(req_ready[0]), 32'd1);
    sbq[0].delete();
    @(posedge clk); #2;
    rstn = 1'b1;
    issue(0, 32'h4); idle(0); drain(0);

    // zero wait states: back-to-back, one word per cycle
    ld(1, 32'h0, 32'h11); ld(1, 32'h4, 32'h22); ld(1, 32'h8, 32'h33);
    c0 = cyc;
    issue(1, 32'h0); issue(1, 32'h4); issue(1, 32'h8);
    c1 = cyc;
    idle(1);
    chk("b2b_cycles", 32'(c1 - c0), 32'd3);
    drain(1);
    issue(1, 32'h2); issue(1, 32'h40); issue(1, 32'h4); idle(1); drain(1);

    // randomized traffic on both units
    for (int u = 0; u < 2; u++) begin
      rdy_mode[u] = 1;
      for (int n = 0; n < 80; n++) begin
        r = $urandom_range(0, 99);
        if (r < 8) begin
          idle(u); drain(u);
          if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, depth_of(u) - 1) * 4);
          else a = $urandom;
          ld(u, a, $urandom);
        end else begin
          r = $urandom_range(0, 99);
          if (r < 70)      a = 32'($urandom_range(0, depth_of(u) - 1) * 4);
          else if (r < 85) a = 32'($urandom_range(0, depth_of(u) - 1) * 4 + $urandom_range(1, 3));
          else if (r < 95) a = 32'(depth_of(u) * 4 + $urandom_range(0, 4095) * 4);
          else             a = 32'hFFFF_FFFC;
          issue(u, a);
          if ($urandom_range(0, 2) == 0) begin
            idle(u);
            @(posedge clk); #2;
          end
        end
      end
      idle(u);
      drain(u);
      rdy_mode[u] = 0;
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch stage's instruction request interface.
- Accepts one word-aligned fetch address per handshake. Returns the 32-bit instruction after a configurable number of wait states, using a valid/ready response handshake.
- Sits between the fetch stage and the on-chip instruction store.
- A side loader port writes program words (bench or boot loader).

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; must be a power of two, >= 2.
- WAIT_CYCLES, 2, extra cycles between request acceptance and response valid; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_req_valid  input  1  fetch request valid.
- o_req_ready  output  1  responder can accept a request this cycle.
- i_req_addr  input  32  fetch byte address.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  fetch stage accepts the response.
- o_rsp_data  output  32  instruction word.
- o_rsp_err  output  1  access fault (misaligned or out of range).
- i_ld_we  input  1  loader write enable.
- i_ld_addr  input  32  loader byte address, same mapping as fetch.
- i_ld_data  input  32  loader write data.

Behaviour:
- Reset:
  - One clock, i_clk; reset is asynchronous and active-low on i_rstn.
  - State goes to IDLE. o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, wait counter=0.
  - o_req_ready=1 in IDLE, including during reset.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid&o_req_ready, capture i_req_addr.
  - If WAIT_CYCLES==0, go to RESP. Otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - o_req_ready=0; counter decrements each cycle.
  - When counter==0, go to RESP.
- Read latch:
  - o_rsp_data/o_rsp_err are registered on the edge that enters RESP.
  - Latency from request handshake to o_rsp_valid=1 is WAIT_CYCLES+1 cycles.
- RESP:
  - o_rsp_valid=1. o_rsp_data and o_rsp_err are held stable until i_rsp_ready=1.
  - o_req_ready=i_rsp_ready, combinational, so back-to-back operation is allowed.
  - On response handshake with a new request handshake in the same cycle: capture the new address and go to WAIT, or re-enter RESP with new data if WAIT_CYCLES==0.
  - On response handshake with no new request: go to IDLE; o_rsp_valid=0 next cycle.
  - With WAIT_CYCLES==0, sustained throughput is 1 word/cycle.
- Error rules:
  - Misaligned: addr[1:0]!=0.
  - Out of range: addr<BASE_ADDR or ((addr-BASE_ADDR)>>2)>=DEPTH_WORDS.
  - On error: o_rsp_err=1, o_rsp_data=32'h0000_0000, memory is not read.
  - The handshake completes normally on error.
- Word index: (addr-BASE_ADDR)>>2, width clog2(DEPTH_WORDS).
- Loader:
  - A write takes effect at the clock edge when i_ld_we=1 and the address is aligned and in range; otherwise it is silently dropped.
  - Loader writes are allowed in any state.
  - Loader write to the same word on the same edge as the read latch: the read returns the OLD data (read-before-write).
  - Writes on earlier edges are visible to the read.
- Reset mid-operation: a pending request or response is abandoned. The next request after reset release is serviced normally.
- Protocol assumption: i_req_addr is only sampled at handshake. Changes while o_req_ready=0 are ignored.

Test Plan:
- Load 0x00500093 at addr 0x0; WAIT_CYCLES=2; request 0x0 -> o_rsp_valid rises 3 cycles after handshake, data 0x00500093, err=0.
- Hold i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid, data and err stay constant; o_req_ready=0 throughout; handshake on cycle 6 returns to IDLE.
- WAIT_CYCLES=0; words 0x11,0x22,0x33 at 0x0,0x4,0x8; back-to-back requests with i_rsp_ready=1 -> one response per cycle, in order 0x11,0x22,0x33.
- Request 0x2 (misaligned), then 0x1000 with DEPTH_WORDS=1024 (out of range) -> each returns err=1, data 0; the next valid request returns correct data.
- Loader writes 0xAAAA_AAAA to 0x10 on the read-latch edge of a request to 0x10 holding 0x5555_5555 -> response 0x5555_5555; a repeat request returns 0xAAAA_AAAA.
- Assert i_rstn=0 during WAIT -> o_rsp_valid=0 immediately, o_req_ready=1; after release, request 0x4 is serviced with correct latency.
